// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   start    : conversion request, sampled only while idle
//   bin      : binary operand, captured when start is accepted
//   busy     : conversion in progress
//   done     : one-cycle pulse, bcd/overflow updated on this cycle's edge
//   bcd      : DIGITS packed BCD digits, digit 0 in bits [3:0]
//   overflow : last operand exceeded 10^DIGITS-1, bcd then holds the value modulo 10^DIGITS
module bin2bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int SW = 4 * DIGITS;
   typedef enum logic {IDLE, CONV} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] sr, sr_nx;
   logic [SW-1:0] scr, adj, scr_nx;
   logic [CW-1:0] cnt;
   logic ovf, out_bit, last;
   assign last = cnt == CW'(1);
   always_comb begin
      adj = scr;
      for (int k = 0; k < DIGITS; k++)
         adj[4*k +: 4] = scr[4*k +: 4] >= 4'd5 ? scr[4*k +: 4] + 4'd3 : scr[4*k +: 4];
   end
   // the bit leaving the top digit is a carry of 10^DIGITS, i.e. overflow
   assign {out_bit, scr_nx, sr_nx} = {adj, sr, 1'b0};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb
      state_nx = state == IDLE ? (start ? CONV : IDLE) : (last ? IDLE : CONV);
   always_comb busy = state == CONV;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sr       <= '0;
         scr      <= '0;
         cnt      <= '0;
         ovf      <= 1'b0;
         done     <= 1'b0;
         bcd      <= '0;
         overflow <= 1'b0;
      end else begin
         done <= state == CONV && last;
         if (state == IDLE && start) begin
            sr  <= bin;
            scr <= '0;
            ovf <= 1'b0;
            cnt <= CW'(WIDTH);
         end else if (state == CONV) begin
            sr  <= sr_nx;
            scr <= scr_nx;
            ovf <= ovf | out_bit;
            cnt <= cnt - CW'(1);
            if (last) begin
               bcd      <= scr_nx;
               overflow <= ovf | out_bit;
            end
         end
      end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: three bin2bcd_seq configurations against a decimal-arithmetic reference model
module tb_bin2bcd_seq;
   logic clk = 1'b0, rst_n = 1'b0;
   logic st [3];
   logic [15:0] b [3];
   logic [11:0] o0;
   logic [7:0] o1;
   logic [19:0] o2;
   logic busy_d [3], done_d [3], ovf_d [3];
   logic [19:0] bcd_d [3];
   logic m_busy [3], m_done [3], m_ovf [3];
   logic [19:0] m_bcd [3];
   int m_rem [3], m_op [3];
   int ncmp = 0, nfail = 0;
   always #5 clk = ~clk;
   bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u0 (.clk(clk), .rst_n(rst_n), .start(st[0]), .bin(b[0][7:0]),
      .busy(busy_d[0]), .done(done_d[0]), .bcd(o0), .overflow(ovf_d[0]));
   bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u1 (.clk(clk), .rst_n(rst_n), .start(st[1]), .bin(b[1][7:0]),
      .busy(busy_d[1]), .done(done_d[1]), .bcd(o1), .overflow(ovf_d[1]));
   bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u2 (.clk(clk), .rst_n(rst_n), .start(st[2]), .bin(b[2]),
      .busy(busy_d[2]), .done(done_d[2]), .bcd(o2), .overflow(ovf_d[2]));
   assign bcd_d[0] = {8'd0, o0};
   assign bcd_d[1] = {12'd0, o1};
   assign bcd_d[2] = o2;
   function automatic int wid(int i);
      return i == 2 ? 16 : 8;
   endfunction
   function automatic int dig(int i);
      return i == 0 ? 3 : i == 1 ? 2 : 5;
   endfunction
   function automatic int pow10(int d);
      int p = 1;
      for (int k = 0; k < d; k++) p *= 10;
      return p;
   endfunction
   function automatic logic [19:0] to_bcd(int v, int d);
      logic [19:0] r = '0;
      for (int k = 0; k < d; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
      return r;
   endfunction
   // reference: operand captured when idle, result appears WIDTH edges later
   always @(posedge clk or negedge rst_n)
      for (int i = 0; i < 3; i++)
         if (!rst_n) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b0;
            m_ovf[i]  <= 1'b0;
            m_bcd[i]  <= '0;
            m_rem[i]  <= 0;
            m_op[i]   <= 0;
         end else begin
            m_done[i] <= 1'b0;
            if (m_busy[i]) begin
               if (m_rem[i] == 1) begin
                  m_busy[i] <= 1'b0;
                  m_done[i] <= 1'b1;
                  m_bcd[i]  <= to_bcd(m_op[i], dig(i));
                  m_ovf[i]  <= m_op[i] >= pow10(dig(i));
               end else m_rem[i] <= m_rem[i] - 1;
            end else if (st[i]) begin
               m_busy[i] <= 1'b1;
               m_rem[i]  <= wid(i);
               m_op[i]   <= int'(b[i]) & ((1 << wid(i)) - 1);
            end
         end
   always @(negedge clk)
      for (int i = 0; i < 3; i++) begin
         ncmp++;
         if (busy_d[i] !== m_busy[i] || done_d[i] !== m_done[i] || bcd_d[i] !== m_bcd[i] || ovf_d[i] !== m_ovf[i]) begin
            nfail++;
            $display("FAIL cycle u%0d: got busy=%b done=%b bcd=%h ovf=%b, need busy=%b done=%b bcd=%h ovf=%b",
               i, busy_d[i], done_d[i], bcd_d[i], ovf_d[i], m_busy[i], m_done[i], m_bcd[i], m_ovf[i]);
         end
      end
   task automatic chk(string name, logic [19:0] act, logic [19:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, need %h", name, act, exp);
      end
   endtask
   // pulse start on instance i with operand v, wait for done; returns busy cycles seen
   task automatic run(int i, int v, output int bcyc);
      bcyc = 0;
      @(negedge clk);
      st[i] = 1'b1;
      b[i] = 16'(v);
      @(negedge clk);
      st[i] = 1'b0;
      for (int n = 0; n < 40 && !done_d[i]; n++) begin
         if (busy_d[i]) bcyc++;
         @(negedge clk);
      end
      if (!done_d[i]) chk("done_timeout", 20'd0, 20'd1);
   endtask
   initial begin
      int c;
      for (int i = 0; i < 3; i++) begin st[i] = 1'b0; b[i] = '0; end
      repeat (2) @(negedge clk);
      chk("reset_bcd", bcd_d[0], 20'h0);
      chk("reset_busy", 20'(busy_d[0]), 20'h0);
      rst_n = 1'b1;
      run(0, 255, c);
      chk("bcd_255", bcd_d[0], 20'h255);
      chk("model_255", m_bcd[0], 20'h255);
      chk("ovf_255", 20'(ovf_d[0]), 20'h0);
      chk("busy_cycles_255", 20'(c), 20'd8);
      run(0, 0, c);
      chk("bcd_0", bcd_d[0], 20'h000);
      run(0, 99, c);
      chk("bcd_99", bcd_d[0], 20'h099);
      run(0, 100, c);
      chk("bcd_100", bcd_d[0], 20'h100);
      run(1, 200, c);
      chk("bcd_200_d2", bcd_d[1], 20'h00);
      chk("ovf_200_d2", 20'(ovf_d[1]), 20'h1);
      chk("model_ovf_200", 20'(m_ovf[1]), 20'h1);
      run(1, 42, c);
      chk("bcd_42_d2", bcd_d[1], 20'h42);
      chk("ovf_42_d2", 20'(ovf_d[1]), 20'h0);
      run(2, 65535, c);
      chk("bcd_65535", bcd_d[2], 20'h65535);
      chk("busy_cycles_65535", 20'(c), 20'd16);
      run(0, 17, c);
      chk("bcd_17", bcd_d[0], 20'h017);
      st[0] = 1'b1;
      b[0] = 16'd38;
      @(negedge clk);
      st[0] = 1'b0;
      for (int n = 0; n < 40 && !done_d[0]; n++) @(negedge clk);
      chk("bcd_b2b_38", bcd_d[0], 20'h038);
      @(negedge clk);
      st[0] = 1'b1;
      b[0] = 16'd123;
      @(negedge clk);
      st[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      st[0] = 1'b1;
      b[0] = 16'd7;
      @(negedge clk);
      st[0] = 1'b0;
      for (int n = 0; n < 40 && !done_d[0]; n++) @(negedge clk);
      chk("bcd_busy_start_123", bcd_d[0], 20'h123);
      repeat (12) @(negedge clk);
      chk("bcd_held_123", bcd_d[0], 20'h123);
      @(negedge clk);
      st[0] = 1'b1;
      b[0] = 16'd250;
      @(negedge clk);
      st[0] = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", 20'(busy_d[0]), 20'h0);
      chk("rst_mid_done", 20'(done_d[0]), 20'h0);
      chk("rst_mid_bcd", bcd_d[0], 20'h0);
      chk("rst_mid_ovf", 20'(ovf_d[0]), 20'h0);
      @(negedge clk);
      rst_n = 1'b1;
      run(0, 9, c);
      chk("bcd_9", bcd_d[0], 20'h009);
      for (int k = 0; k < 200; k++) begin
         int v = int'($urandom_range(0, 65535));
         run(2, v, c);
         chk("rand16", bcd_d[2], to_bcd(v, 5));
      end
      for (int k = 0; k < 30; k++) run(int'($urandom_range(0, 1)), int'($urandom_range(0, 255)), c);
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
